// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the RV32I pipeline hazard/control unit.
package pipeline_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  // Operand source selects driven into the EX-stage operand muxes
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Data-memory wait FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
// Combinational forwarding selects and ID-stage dependency detection.
// With forwarding enabled only a load in EX forces a stall; without it
// any valid writer in EX/MEM/WB that feeds ID forces a stall.
module hazard_fwd_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int FWD_EN     = 1
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite_en,
  input  logic                  ex_is_load,
  input  logic                  v_ex,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite_en,
  input  logic                  v_mem,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite_en,
  input  logic                  v_wb,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  hazard
);

  // Youngest producer (MEM) wins over WB; x0 is never forwarded
  function automatic logic [1:0] pick(input logic [REG_ADDR_W-1:0] rs,
                                      input logic mw, input logic [REG_ADDR_W-1:0] mrd,
                                      input logic ww, input logic [REG_ADDR_W-1:0] wrd);
    if (rs != '0 && mw && mrd == rs) return FWD_MEM;
    if (rs != '0 && ww && wrd == rs) return FWD_WB;
    return FWD_RF;
  endfunction

  // Does the ID instruction actually read register rd (x0 excluded)
  function automatic logic reads(input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] r1, input logic u1,
                                 input logic [REG_ADDR_W-1:0] r2, input logic u2);
    return (rd != '0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
  endfunction

  logic mem_wr, wb_wr, load_use, raw;

  assign mem_wr = v_mem & mem_regwrite_en;
  assign wb_wr  = v_wb & wb_regwrite_en;

  assign load_use = v_ex & ex_is_load & reads(ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);
  assign raw = (v_ex & ex_regwrite_en & reads(ex_rd,  id_rs1, id_use_rs1, id_rs2, id_use_rs2))
             | (mem_wr & reads(mem_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2))
             | (wb_wr  & reads(wb_rd,  id_rs1, id_use_rs1, id_rs2, id_use_rs2));

  assign fwd_a_sel = (FWD_EN != 0) ? pick(ex_rs1, mem_wr, mem_rd, wb_wr, wb_rd) : FWD_RF;
  assign fwd_b_sel = (FWD_EN != 0) ? pick(ex_rs2, mem_wr, mem_rd, wb_wr, wb_rd) : FWD_RF;
  assign hazard    = (FWD_EN != 0) ? load_use : raw;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV32I core: stage valid
// bits, stall/flush generation, data-memory wait FSM and perf counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_LATENCY = 0,
  parameter int FWD_EN      = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite_en,
  input  logic                  ex_is_load,
  input  logic                  ex_pc_sel,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite_en,
  input  logic                  mem_access,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite_en,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  v_id,
  output logic                  v_ex,
  output logic                  v_mem,
  output logic                  v_wb,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  mem_state_t state;
  logic [3:0] wait_cnt;
  logic       done;
  logic [1:0] fwd_a, fwd_b;
  logic       hazard, start, mem_wait, redirect, hold_front, kill_ex;

  hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd (
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite_en(ex_regwrite_en),
    .ex_is_load(ex_is_load), .v_ex(v_ex),
    .mem_rd(mem_rd), .mem_regwrite_en(mem_regwrite_en), .v_mem(v_mem),
    .wb_rd(wb_rd), .wb_regwrite_en(wb_regwrite_en), .v_wb(v_wb),
    .fwd_a_sel(fwd_a), .fwd_b_sel(fwd_b), .hazard(hazard)
  );

  // The triggering cycle is the first stall cycle; the WAIT cycle with
  // wait_cnt == 1 lets MEM drain, so MEM is held exactly MEM_LATENCY cycles.
  assign start      = (MEM_LATENCY != 0) && state == ST_IDLE && v_mem && mem_access && !done;
  assign mem_wait   = start | (state == ST_WAIT && wait_cnt != 4'd1);
  // A branch held in EX during a wait resolves on the first unstalled cycle
  assign redirect   = v_ex & ex_pc_sel & ~mem_wait;
  assign hold_front = mem_wait | (hazard & ~redirect);
  assign kill_ex    = redirect | (hazard & ~mem_wait);

  assign fwd_a_sel = rst ? FWD_RF : fwd_a;
  assign fwd_b_sel = rst ? FWD_RF : fwd_b;
  assign stall_if  = ~rst & hold_front;
  assign stall_id  = ~rst & hold_front;
  assign stall_ex  = ~rst & mem_wait;
  assign stall_mem = ~rst & mem_wait;
  assign flush_id  = ~rst & redirect;
  assign flush_ex  = ~rst & kill_ex;

  // Memory-wait FSM; done blocks re-triggering until MEM advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= start | (done & mem_wait);
      case (state)
        ST_IDLE: if (start) begin
          state    <= ST_WAIT;
          wait_cnt <= LAT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage valid bits; stalled stages hold, WB takes a bubble during a wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_id  <= 1'b0;
      v_ex  <= 1'b0;
      v_mem <= 1'b0;
      v_wb  <= 1'b0;
    end else begin
      if (!hold_front) v_id <= ~redirect;
      if (!mem_wait) begin
        v_ex  <= v_id & ~kill_ex;
        v_mem <= v_ex;
      end
      v_wb <= v_mem & ~mem_wait;
    end
  end

  // Saturating stall and redirect counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold_front && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && flush_cnt != '1)   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven by shared inputs
// (A: forwarding, 3-cycle memory, 32-bit counters; B: stall-only, single-cycle
// memory, 4-bit counters) checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite_en, ex_is_load, ex_pc_sel;
  logic mem_regwrite_en, mem_access, wb_regwrite_en;

  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic a_sif, a_sid, a_sex, a_smem, a_fid, a_fex, a_vid, a_vex, a_vmem, a_vwb;
  logic b_sif, b_sid, b_sex, b_smem, b_fid, b_fex, b_vid, b_vex, b_vmem, b_vwb;
  logic [31:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LATENCY(3), .FWD_EN(1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite_en(ex_regwrite_en), .ex_is_load(ex_is_load), .ex_pc_sel(ex_pc_sel),
    .mem_rd(mem_rd), .mem_regwrite_en(mem_regwrite_en), .mem_access(mem_access),
    .wb_rd(wb_rd), .wb_regwrite_en(wb_regwrite_en),
    .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .stall_if(a_sif), .stall_id(a_sid),
    .stall_ex(a_sex), .stall_mem(a_smem), .flush_id(a_fid), .flush_ex(a_fex),
    .v_id(a_vid), .v_ex(a_vex), .v_mem(a_vmem), .v_wb(a_vwb),
    .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LATENCY(0), .FWD_EN(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite_en(ex_regwrite_en), .ex_is_load(ex_is_load), .ex_pc_sel(ex_pc_sel),
    .mem_rd(mem_rd), .mem_regwrite_en(mem_regwrite_en), .mem_access(mem_access),
    .wb_rd(wb_rd), .wb_regwrite_en(wb_regwrite_en),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .stall_if(b_sif), .stall_id(b_sid),
    .stall_ex(b_sex), .stall_mem(b_smem), .flush_id(b_fid), .flush_ex(b_fex),
    .v_id(b_vid), .v_ex(b_vex), .v_mem(b_vmem), .v_wb(b_vwb),
    .stall_cnt(b_sc), .flush_cnt(b_fc));

  logic [13:0] ctl [2];
  logic [31:0] sc [2];
  logic [31:0] fc [2];
  assign ctl[0] = {a_fa, a_fb, a_sif, a_sid, a_sex, a_smem, a_fid, a_fex, a_vid, a_vex, a_vmem, a_vwb};
  assign ctl[1] = {b_fa, b_fb, b_sif, b_sid, b_sex, b_smem, b_fid, b_fex, b_vid, b_vex, b_vmem, b_vwb};
  assign sc[0] = a_sc;
  assign fc[0] = a_fc;
  assign sc[1] = {28'd0, b_sc};
  assign fc[1] = {28'd0, b_fc};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: wait_left counts remaining stall cycles of an access
  bit     m_vid [2], m_vex [2], m_vmem [2], m_vwb [2], m_done [2];
  int     m_wait [2];
  longint m_sc [2], m_fc [2];
  logic [13:0] e_ctl [2];
  logic [31:0] e_sc [2], e_fc [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vid[k] = 0; m_vex[k] = 0; m_vmem[k] = 0; m_vwb[k] = 0; m_done[k] = 0;
      m_wait[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  function automatic bit reads(input int rd);
    return rd != 0 && ((id_use_rs1 && int'(id_rs1) == rd) || (id_use_rs2 && int'(id_rs2) == rd));
  endfunction

  function automatic logic [1:0] src(input int rs, input int k);
    if (rs == 0) return 2'b00;
    if (m_vmem[k] && mem_regwrite_en && int'(mem_rd) == rs) return 2'b10;
    if (m_vwb[k] && wb_regwrite_en && int'(wb_rd) == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_cycle(input int k);
    int     lat = (k == 0) ? 3 : 0;
    bit     fwd = (k == 0);
    longint mx  = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
    bit trig, mw, haz, redir, hold, kill;
    trig = m_wait[k] == 0 && lat > 0 && m_vmem[k] && mem_access && !m_done[k];
    if (trig) m_wait[k] = lat;
    mw = m_wait[k] > 0;
    if (fwd) haz = m_vex[k] && ex_is_load && reads(ex_rd);
    else haz = (m_vex[k] && ex_regwrite_en && reads(ex_rd)) ||
               (m_vmem[k] && mem_regwrite_en && reads(mem_rd)) ||
               (m_vwb[k] && wb_regwrite_en && reads(wb_rd));
    redir = m_vex[k] && ex_pc_sel && !mw;
    hold  = mw || (haz && !redir);
    kill  = redir || (haz && !mw);
    e_ctl[k] = {fwd ? src(ex_rs1, k) : 2'b00, fwd ? src(ex_rs2, k) : 2'b00,
                hold, hold, mw, mw, redir, kill, m_vid[k], m_vex[k], m_vmem[k], m_vwb[k]};
    e_sc[k] = m_sc[k][31:0];
    e_fc[k] = m_fc[k][31:0];
    m_vwb[k] = m_vmem[k] && !mw;
    if (!mw) begin
      m_vmem[k] = m_vex[k];
      m_vex[k]  = m_vid[k] && !kill;
    end
    if (!hold) m_vid[k] = !redir;
    m_done[k] = trig ? 1'b1 : (mw ? m_done[k] : 1'b0);
    if (m_wait[k] > 0) m_wait[k]--;
    if (hold && m_sc[k] < mx) m_sc[k]++;
    if (redir && m_fc[k] < mx) m_fc[k]++;
  endtask

  // pre: sample at negedge+1 and compare; post: commit the edge, return at posedge+1
  task automatic pre();
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_cycle(k);
      chk(k == 0 ? "ctl_a" : "ctl_b", {18'd0, ctl[k]}, {18'd0, e_ctl[k]});
      chk(k == 0 ? "scnt_a" : "scnt_b", sc[k], e_sc[k]);
      chk(k == 0 ? "fcnt_a" : "fcnt_b", fc[k], e_fc[k]);
    end
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic idle_in();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite_en = 0; ex_is_load = 0; ex_pc_sel = 0;
    mem_rd = 0; mem_regwrite_en = 0; mem_access = 0; wb_rd = 0; wb_regwrite_en = 0;
  endtask

  initial begin
    int n;
    bit last;
    idle_in();
    model_reset();
    #3;
    chk("rst_ctl_a", {18'd0, ctl[0]}, 32'd0);
    chk("rst_ctl_b", {18'd0, ctl[1]}, 32'd0);
    chk("rst_cnt_a", a_sc | a_fc, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // fill the pipeline
    repeat (4) step();

    // forwarding priority and x0
    ex_rs1 = 5; mem_rd = 5; mem_regwrite_en = 1; wb_rd = 5; wb_regwrite_en = 1;
    pre(); chk("fwd_mem", 32'(a_fa), 32'h2); chk("fwd_off", 32'(b_fa), 32'h0); post();
    mem_rd = 6;
    pre(); chk("fwd_wb", 32'(a_fa), 32'h1); post();
    ex_rs1 = 0;
    pre(); chk("fwd_x0", 32'(a_fa), 32'h0); post();
    idle_in();

    // load-use: one stall cycle, bubble into EX
    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    pre(); chk("lu_sif", 32'(a_sif), 1); chk("lu_sid", 32'(a_sid), 1); chk("lu_fex", 32'(a_fex), 1); post();
    pre(); chk("lu_once", 32'(a_sif), 0); chk("lu_vex", 32'(a_vex), 0); post();
    chk("lu_scnt", a_sc, 1);

    // branch beats a simultaneous load-use
    ex_pc_sel = 1;
    pre(); chk("br_fid", 32'(a_fid), 1); chk("br_fex", 32'(a_fex), 1); chk("br_sif", 32'(a_sif), 0); post();
    chk("br_vex", 32'(a_vex), 0); chk("br_vid", 32'(a_vid), 0); chk("br_fcnt", a_fc, 1);
    idle_in();
    repeat (4) step();

    // 3-cycle memory wait, then drain without re-trigger
    mem_access = 1;
    n = 0; last = 0;
    for (int i = 0; i < 4; i++) begin
      pre();
      if (a_smem) n++;
      last = a_smem;
      post();
    end
    chk("mw_len", n, 3);
    chk("mw_drain", 32'(last), 0);
    chk("mw_wb", 32'(a_vwb), 1);

    // next access starts a wait; reset lands mid-WAIT between edges
    pre(); chk("mw_again", 32'(a_smem), 1); post();
    #1 rst = 1'b1;
    #1;
    chk("arst_ctl_a", {18'd0, ctl[0]}, 32'd0);
    chk("arst_cnt_a", a_sc | a_fc, 32'd0);
    chk("arst_ctl_b", {18'd0, ctl[1]}, 32'd0);
    idle_in();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step();
    chk("arst_vid", 32'(a_vid), 1);
    repeat (3) step();

    // no forwarding: producer walks EX -> MEM -> WB, ID held for three cycles
    id_rs1 = 9; id_use_rs1 = 1; ex_rd = 9; ex_regwrite_en = 1;
    n = 0; last = 0;
    for (int i = 0; i < 4; i++) begin
      pre();
      if (b_sid) n++;
      last = b_sid;
      chk("raw_fwd", 32'({b_fa, b_fb}), 0);
      post();
      ex_regwrite_en = 0;
      mem_rd = (i == 0) ? 5'd9 : 5'd0; mem_regwrite_en = (i == 0);
      wb_rd  = (i == 1) ? 5'd9 : 5'd0; wb_regwrite_en  = (i == 1);
    end
    chk("raw_len", n, 3);
    chk("raw_end", 32'(last), 0);
    idle_in();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7));
      ex_rd  = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7));
      wb_rd  = 5'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_regwrite_en = 1'($urandom); mem_regwrite_en = 1'($urandom); wb_regwrite_en = 1'($urandom);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_pc_sel  = ($urandom_range(0, 7) == 0);
      mem_access = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Successor to the free-running pipeline, which has no hazard handling.
- Generates forwarding selects, load-use stalls, branch/jump flushes and multi-cycle data-memory wait stalls.
- Tracks a valid bit per stage and keeps saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 5, register-file address width.
MEM_LATENCY, 0, extra wait cycles per data-memory access (0..15); 0 means single-cycle memory.
FWD_EN, 1, 1 = EX forwarding enabled; 0 = resolve every RAW hazard by stalling in ID.
CNT_W, 32, performance counter width.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  instruction in ID actually reads rs1/rs2
ex_rs1, ex_rs2  in  REG_ADDR_W  source registers held in ID/EX
ex_rd  in  REG_ADDR_W  destination held in ID/EX
ex_regwrite_en  in  1  ID/EX register-write enable
ex_is_load  in  1  ID/EX instruction is a load (wb_sel=1)
ex_pc_sel  in  1  branch taken or jump resolved in EX
mem_rd  in  REG_ADDR_W  destination held in EX/MEM
mem_regwrite_en  in  1  EX/MEM register-write enable
mem_access  in  1  EX/MEM instruction is a load or store
wb_rd  in  REG_ADDR_W  destination held in MEM/WB
wb_regwrite_en  in  1  MEM/WB register-write enable
fwd_a_sel, fwd_b_sel  out  2  00 = register file, 10 = EX/MEM ALU out, 01 = WB data
stall_if, stall_id, stall_ex, stall_mem  out  1  hold the PC / pipeline register of that stage
flush_id, flush_ex  out  1  insert a bubble into IF/ID or ID/EX
v_id, v_ex, v_mem, v_wb  out  1  stage valid bits
stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

Behaviour:
- Reset (async, any cycle, including mid-wait): v_* = 0, FSM = IDLE, wait counter = 0, both perf counters = 0.
- During reset all stall/flush/forwarding outputs are 0.
- Valid pipeline: registered, updated only for non-stalled stages.
  - v_id <= 1 unless flush_id.
  - v_ex <= v_id & ~flush_ex.
  - v_mem <= v_ex.
  - v_wb <= v_mem & ~mem_wait.
  - A stalled stage holds its bit.
- Forwarding (FWD_EN=1, combinational), evaluated for fwd_a_sel/rs1 and fwd_b_sel/rs2:
  - 10 if v_mem & mem_regwrite_en & mem_rd != 0 & mem_rd == ex_rsX.
  - Otherwise 01 if v_wb & wb_regwrite_en & wb_rd == ex_rsX & wb_rd != 0.
  - Otherwise 00. MEM has priority over WB.
- FWD_EN=0: fwd_* = 00 always. raw_stall is asserted when a used id_rsX (nonzero) matches the rd of any valid, writing instruction in EX, MEM or WB.
- Load-use stall (FWD_EN=1): v_ex & ex_is_load & ex_rd != 0 & ex_rd matches a used id_rsX.
  - Effect: stall_if = stall_id = 1 and flush_ex = 1 for exactly one cycle.
- Branch flush: redirect = v_ex & ex_pc_sel & ~mem_wait.
  - Effect: flush_id = flush_ex = 1, giving two bubbles.
  - Priority: redirect beats load-use/raw stall. stall_if/stall_id are cleared that cycle so the PC takes the target.
- Memory-wait FSM, states IDLE and WAIT:
  - IDLE -> WAIT when MEM_LATENCY > 0, v_mem & mem_access, and the access has not already been waited on; counter loads MEM_LATENCY.
  - In WAIT: mem_wait = 1. stall_if/id/ex/mem = 1, WB receives a bubble, counter decrements.
  - WAIT -> IDLE when counter == 1. The instruction advances on the next edge.
  - A done flag prevents re-triggering on the same instruction; it is cleared when MEM advances.
  - A branch pending in EX during WAIT is held and flushes on the first IDLE cycle.
  - With MEM_LATENCY = 0 the FSM stays IDLE.
- Perf counters:
  - stall_cnt increments on every cycle with stall_if = 1.
  - flush_cnt increments once per redirect.
  - Both saturate at 2^CNT_W - 1.
- Register x0 never triggers forwarding or stalls.

Decomposition:
- Package pipeline_pkg holds FWD_RF=2'b00, FWD_MEM=2'b10 and FWD_WB=2'b01, the FSM state encoding, and the REG_ADDR_W default.
- One natural sub-module, hazard_fwd_unit: the combinational forwarding and dependency comparators.
- The top module holds the valid bits, FSM and counters.

Test Plan:
- Forwarding: add x5 in MEM (v_mem=1, mem_rd=5, regwrite) and ex_rs1=5; also wb_rd=5 writing -> fwd_a_sel=10. Then with mem_rd=6 -> fwd_a_sel=01. With ex_rs1=0 -> 00.
- Load-use: ex_is_load, ex_rd=7, id_rs2=7, id_use_rs2=1 -> stall_if=stall_id=flush_ex=1 for exactly 1 cycle, v_ex=0 next cycle, stall_cnt=1.
- Branch: ex_pc_sel=1, v_ex=1 while a load-use condition is also present -> flush_id=flush_ex=1, stall_if=0, flush_cnt=1, v_ex=v_id=0 next cycle.
- MEM_LATENCY=3: a load enters MEM -> stall_mem=1 for exactly 3 cycles, v_wb=0 during the wait, then the load reaches WB; no re-trigger follows.
- FWD_EN=0: dependent instruction in ID with the producer in EX -> stall_id held for 3 cycles until the producer leaves WB, and fwd_* stays 00.
- Reset asserted mid-WAIT (async, between edges) -> all outputs 0 immediately, FSM = IDLE, counters = 0; after deassertion v_id rises on the first edge.
